// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port indices,
// arbitration FSM encoding and default widths.
package ram_arb_pkg;

   localparam int PORT_CPU  = 0;
   localparam int PORT_LOAD = 1;

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int ADDRESS_WIDTH_DEF = 12;
   localparam int CNT_WIDTH_DEF     = 16;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester, RAM-side and debug signals around the arbiter.
// slave  : the arbiter's view.
// master : the environment's view (requesters, RAM, debug reader).
interface ram_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int CNT_WIDTH     = 16
) ();

   logic                     req_0;
   logic                     req_1;
   logic                     we_0;
   logic                     we_1;
   logic [ADDRESS_WIDTH-1:0] addr_0;
   logic [ADDRESS_WIDTH-1:0] addr_1;
   logic [DATA_WIDTH-1:0]    wdata_0;
   logic [DATA_WIDTH-1:0]    wdata_1;
   logic                     lock_1;
   logic                     gnt_0;
   logic                     gnt_1;
   logic                     rvalid_0;
   logic                     rvalid_1;
   logic [DATA_WIDTH-1:0]    rdata_0;
   logic [DATA_WIDTH-1:0]    rdata_1;
   logic                     ram_wEn;
   logic [ADDRESS_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_dataIn;
   logic [DATA_WIDTH-1:0]    ram_dataOut;
   logic [CNT_WIDTH-1:0]     conflicts;

   modport slave (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      input  lock_1, ram_dataOut,
      output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
      output ram_wEn, ram_addr, ram_dataIn, conflicts
   );

   modport master (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      output lock_1, ram_dataOut,
      input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
      input  ram_wEn, ram_addr, ram_dataIn, conflicts
   );

endinterface

// File: rtl/ram_rr_pick.sv
// Combinational 2-way round-robin selector. When lock_only_1 is set only
// port 1 can win, even if port 0 is the sole requester.
module ram_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   input  logic       i_lock_only_1,
   output logic [1:0] o_gnt
);

   // Pick at most one winner; on contention the port not granted last wins.
   always_comb begin
      o_gnt = 2'b00;
      if (i_lock_only_1) begin
         o_gnt[1] = i_req[1];
      end else if (i_req == 2'b11) begin
         if (i_last_gnt) o_gnt[0] = 1'b1;
         else            o_gnt[1] = 1'b1;
      end else begin
         o_gnt = i_req;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a falling-edge single-port RAM between the CPU memory stage
// (port 0) and the loader/debug port (port 1).
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_OPEN   | normal round-robin arbitration between both ports
//   ST_LOCKED | port 1 owns the RAM; port 0 is never granted
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   ram_arbiter_if.slave bus
);

   arb_state_t            r_state;
   arb_state_t            w_state_next;
   logic                  r_last_gnt;
   logic [1:0]            w_req;
   logic [1:0]            w_pick;
   logic [1:0]            w_gnt;
   logic                  w_lock_only;
   logic                  w_rd_pend_0;
   logic                  w_rd_pend_1;
   logic                  r_rvalid_0;
   logic                  r_rvalid_1;
   logic [DATA_WIDTH-1:0] r_rdata_0;
   logic [DATA_WIDTH-1:0] r_rdata_1;
   logic [CNT_WIDTH-1:0]  r_conflicts;

   assign w_req       = {bus.req_1, bus.req_0};
   assign w_lock_only = (r_state == ST_LOCKED);

   ram_rr_pick u_pick (
      .i_req         (w_req),
      .i_last_gnt    (r_last_gnt),
      .i_lock_only_1 (w_lock_only),
      .o_gnt         (w_pick)
   );

   // Reset masks grants so the RAM sees no access while reset is high.
   assign w_gnt       = reset ? 2'b00 : w_pick;
   assign w_rd_pend_0 = w_gnt[PORT_CPU]  & ~bus.we_0;
   assign w_rd_pend_1 = w_gnt[PORT_LOAD] & ~bus.we_1;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_OPEN;
      else       r_state <= w_state_next;
   end

   // FSM next state: lock taken on a locked port-1 grant, released when lock_1 drops.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_OPEN:   if (w_gnt[PORT_LOAD] && bus.lock_1) w_state_next = ST_LOCKED;
         ST_LOCKED: if (!bus.lock_1)                    w_state_next = ST_OPEN;
         default:   w_state_next = ST_OPEN;
      endcase
   end

   // Remember the most recent winner for round-robin; port 0 wins first after reset.
   always_ff @(posedge clk) begin
      if (reset)                 r_last_gnt <= 1'b1;
      else if (w_gnt[PORT_CPU])  r_last_gnt <= 1'b0;
      else if (w_gnt[PORT_LOAD]) r_last_gnt <= 1'b1;
   end

   // RAM drive: granted port's command, port 0's address/data when idle.
   always_comb begin
      bus.ram_wEn    = 1'b0;
      bus.ram_addr   = bus.addr_0;
      bus.ram_dataIn = bus.wdata_0;
      if (w_gnt[PORT_LOAD]) begin
         bus.ram_wEn    = bus.we_1;
         bus.ram_addr   = bus.addr_1;
         bus.ram_dataIn = bus.wdata_1;
      end else if (w_gnt[PORT_CPU]) begin
         bus.ram_wEn    = bus.we_0;
      end
   end

   // Capture RAM read data for the port whose read was granted this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid_0 <= 1'b0;
         r_rvalid_1 <= 1'b0;
         r_rdata_0  <= '0;
         r_rdata_1  <= '0;
      end else begin
         r_rvalid_0 <= w_rd_pend_0;
         r_rvalid_1 <= w_rd_pend_1;
         if (w_rd_pend_0) r_rdata_0 <= bus.ram_dataOut;
         if (w_rd_pend_1) r_rdata_1 <= bus.ram_dataOut;
      end
   end

   // Saturating count of cycles where both ports request.
   always_ff @(posedge clk) begin
      if (reset)
         r_conflicts <= '0;
      else if (bus.req_0 && bus.req_1 && (r_conflicts != '1))
         r_conflicts <= r_conflicts + CNT_WIDTH'(1);
   end

   assign bus.gnt_0     = w_gnt[PORT_CPU];
   assign bus.gnt_1     = w_gnt[PORT_LOAD];
   assign bus.rvalid_0  = r_rvalid_0;
   assign bus.rvalid_1  = r_rvalid_1;
   assign bus.rdata_0   = r_rdata_0;
   assign bus.rdata_1   = r_rdata_1;
   assign bus.conflicts = r_conflicts;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a falling-edge RAM model, a shadow
// memory and per-port read-response queues.
module tb_ram_arbiter;

   logic clk;
   logic reset;

   ram_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .CNT_WIDTH(4)) bus ();

   ram_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .CNT_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] ram_mem [0:4095];
   logic [31:0] sh      [0:4095];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [3:0]  exp_conf;
   int          total;
   int          bad;

   function automatic logic [31:0] init_word(input int idx);
      return 32'hC0DE_0000 ^ 32'(idx);
   endfunction

   always #5 clk = ~clk;

   // RAM model: write or registered read at the falling edge.
   always @(negedge clk) begin
      if (bus.ram_wEn) ram_mem[bus.ram_addr] = bus.ram_dataIn;
      else             bus.ram_dataOut = ram_mem[bus.ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One cycle: drive at posedge+1, check grant side at +2, responses at next posedge+1.
   task automatic step(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                       input logic l1, input logic eg0, input logic eg1, input string tag);
      logic p0, p1, ew;
      logic [31:0] e;
      bus.req_0 = r0; bus.we_0 = w0; bus.addr_0 = a0; bus.wdata_0 = d0;
      bus.req_1 = r1; bus.we_1 = w1; bus.addr_1 = a1; bus.wdata_1 = d1;
      bus.lock_1 = l1;
      #1;
      chk({tag, ".gnt_0"}, 32'(bus.gnt_0), 32'(eg0));
      chk({tag, ".gnt_1"}, 32'(bus.gnt_1), 32'(eg1));
      ew = (eg0 & w0) | (eg1 & w1);
      chk({tag, ".ram_wEn"}, 32'(bus.ram_wEn), 32'(ew));
      if (eg0 | eg1) chk({tag, ".ram_addr"}, 32'(bus.ram_addr), 32'(eg1 ? a1 : a0));
      if (ew)        chk({tag, ".ram_dataIn"}, bus.ram_dataIn, eg1 ? d1 : d0);
      p0 = eg0 & ~w0;
      p1 = eg1 & ~w1;
      if (p0) q0.push_back(sh[a0]);
      if (p1) q1.push_back(sh[a1]);
      if (eg0 & w0) sh[a0] = d0;
      if (eg1 & w1) sh[a1] = d1;
      if (r0 & r1 && exp_conf != 4'hF) exp_conf = exp_conf + 4'd1;
      @(posedge clk); #1;
      chk({tag, ".rvalid_0"}, 32'(bus.rvalid_0), 32'(p0));
      chk({tag, ".rvalid_1"}, 32'(bus.rvalid_1), 32'(p1));
      if (bus.rvalid_0) begin
         e = (q0.size() > 0) ? q0.pop_front() : 32'hXXXX_XXXX;
         chk({tag, ".rdata_0"}, bus.rdata_0, e);
      end
      if (bus.rvalid_1) begin
         e = (q1.size() > 0) ? q1.pop_front() : 32'hXXXX_XXXX;
         chk({tag, ".rdata_1"}, bus.rdata_1, e);
      end
      chk({tag, ".conflicts"}, 32'(bus.conflicts), 32'(exp_conf));
   endtask

   initial begin
      total = 0; bad = 0; exp_conf = 4'd0;
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = init_word(i);
         sh[i]      = init_word(i);
      end
      clk = 1'b0;
      reset = 1'b1;
      bus.ram_dataOut = 32'h0;
      bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 12'h7; bus.wdata_0 = 32'h1;
      bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 12'h8; bus.wdata_1 = 32'h2;
      bus.lock_1 = 1'b0;

      // Reset held two cycles with both ports requesting.
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rst.gnt_0",   32'(bus.gnt_0),   32'd0);
         chk("rst.gnt_1",   32'(bus.gnt_1),   32'd0);
         chk("rst.ram_wEn", 32'(bus.ram_wEn), 32'd0);
         @(posedge clk); #1;
         chk("rst.rvalid_0",  32'(bus.rvalid_0),  32'd0);
         chk("rst.rvalid_1",  32'(bus.rvalid_1),  32'd0);
         chk("rst.rdata_0",   bus.rdata_0,        32'd0);
         chk("rst.conflicts", 32'(bus.conflicts), 32'd0);
      end
      reset = 1'b0;

      // Round-robin contention: first contention goes to port 0, then alternates.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0,
              (i % 2) == 0, (i % 2) == 1, "rr");
      chk("rr.conflicts4", 32'(bus.conflicts), 32'd4);

      // Write then read back on port 0.
      step(1'b1, 1'b1, 12'h123, 32'hDEADBEEF, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, "wr");
      step(1'b1, 1'b0, 12'h123, 32'h0,        1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, "rd");
      chk("rd.rdata_0_direct", bus.rdata_0, 32'hDEADBEEF);

      // Locked port-1 burst while port 0 keeps requesting.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 12'h050, 32'h0, 1'b1, 1'b1, 12'(i), 32'h1000_0000 + 32'(i), 1'b1,
              1'b0, 1'b1, "lock");
      step(1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, "lock_rel");
      step(1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, "lock_after");
      step(1'b0, 1'b0, 12'h0,   32'h0, 1'b1, 1'b0, 12'h002, 32'h0, 1'b0, 1'b0, 1'b1, "burst_rd");

      // Locked with port 1 idle: nothing granted.
      step(1'b0, 1'b0, 12'h0,   32'h0,  1'b1, 1'b0, 12'h003, 32'h0, 1'b1, 1'b0, 1'b1, "lk_enter");
      step(1'b1, 1'b1, 12'h060, 32'h55, 1'b0, 1'b0, 12'h0,   32'h0, 1'b1, 1'b0, 1'b0, "lk_idle");
      step(1'b1, 1'b1, 12'h060, 32'h55, 1'b0, 1'b0, 12'h0,   32'h0, 1'b1, 1'b0, 1'b0, "lk_idle");
      step(1'b1, 1'b1, 12'h060, 32'h55, 1'b0, 1'b0, 12'h0,   32'h0, 1'b0, 1'b0, 1'b0, "lk_drop");
      step(1'b1, 1'b1, 12'h060, 32'h55, 1'b0, 1'b0, 12'h0,   32'h0, 1'b0, 1'b1, 1'b0, "lk_free");

      // Read granted, reset arrives before the capturing edge: no response.
      bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 12'h060;
      bus.req_1 = 1'b0; bus.lock_1 = 1'b0;
      #1;
      chk("mid.gnt_0", 32'(bus.gnt_0), 32'd1);
      #4;
      reset = 1'b1;
      bus.req_0 = 1'b0;
      @(posedge clk); #1;
      chk("mid.rvalid_0",  32'(bus.rvalid_0),  32'd0);
      chk("mid.rvalid_1",  32'(bus.rvalid_1),  32'd0);
      chk("mid.rdata_0",   bus.rdata_0,        32'd0);
      chk("mid.conflicts", 32'(bus.conflicts), 32'd0);
      exp_conf = 4'd0;
      reset = 1'b0;

      // Long contention saturates the 4-bit counter.
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0,
              (i % 2) == 0, (i % 2) == 1, "sat");
      chk("sat.conflicts15", 32'(bus.conflicts), 32'd15);

      bus.req_0 = 1'b0; bus.req_1 = 1'b0;
      chk("end.q0_empty", 32'(q0.size()), 32'd0);
      chk("end.q1_empty", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
